// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: gathers N_POINTS decimated ADC samples per frame into the FFT input stream.
// Optional WAIT_RES watchdog enabled by defining FFT_TIMEOUT_EN.  Rev 1.0
`default_nettype none

module fft_frame_ctrl #(
  parameter int N_POINTS    = 1024,
  parameter int CNT_W       = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_continuous,
  input  logic [7:0]  i_decim,
  input  logic [15:0] i_holdoff,
  input  logic [15:0] ad_data_in,
  input  logic        ad_valid,
  output logic [15:0] fft_data,
  output logic        fft_valid,
  output logic        fft_last,
  input  logic        fft_res_valid,
  input  logic        fft_res_last,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt,
  output logic        o_err_timeout
);

  if (N_POINTS < 8 || N_POINTS != (1 << CNT_W) || TIMEOUT_CYC < 1) begin : g_param_err
    $error("fft_frame_ctrl: bad N_POINTS/CNT_W/TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FILL     = 2'd1,
    S_WAIT_RES = 2'd2,
    S_GAP      = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               cont_q, cont_d;
  logic [7:0]         decim_q, decim_d;
  logic [15:0]        holdoff_q, holdoff_d;
  logic               stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [7:0]         dec_cnt_q, dec_cnt_d;
  logic [15:0]        gap_cnt_q, gap_cnt_d;
  logic [15:0]        fft_data_q, fft_data_d;
  logic               fft_valid_q, fft_valid_d;
  logic               fft_last_q, fft_last_d;
  logic               done_q, done_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

`ifdef FFT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic               err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cont_q      <= 1'b0;
      decim_q     <= '0;
      holdoff_q   <= '0;
      stop_pend_q <= 1'b0;
      smp_cnt_q   <= '0;
      dec_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      fft_data_q  <= '0;
      fft_valid_q <= 1'b0;
      fft_last_q  <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
`ifdef FFT_TIMEOUT_EN
      wd_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      decim_q     <= decim_d;
      holdoff_q   <= holdoff_d;
      stop_pend_q <= stop_pend_d;
      smp_cnt_q   <= smp_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      fft_data_q  <= fft_data_d;
      fft_valid_q <= fft_valid_d;
      fft_last_q  <= fft_last_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef FFT_TIMEOUT_EN
      wd_cnt_q    <= wd_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    decim_d     = decim_q;
    holdoff_d   = holdoff_q;
    stop_pend_d = stop_pend_q;
    smp_cnt_d   = smp_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    fft_data_d  = fft_data_q;
    fft_valid_d = 1'b0;
    fft_last_d  = 1'b0;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
`ifdef FFT_TIMEOUT_EN
    wd_cnt_d    = wd_cnt_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          state_d     = S_FILL;
          cont_d      = i_continuous;
          decim_d     = i_decim;
          holdoff_d   = i_holdoff;
          stop_pend_d = 1'b0;
          smp_cnt_d   = '0;
          dec_cnt_d   = '0;
`ifdef FFT_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
      end

      S_FILL: begin
        if (i_stop) stop_pend_d = 1'b1;
        if (ad_valid) begin
          dec_cnt_d = (dec_cnt_q == decim_q) ? 8'd0 : dec_cnt_q + 8'd1;
          if (dec_cnt_q == 8'd0) begin
            fft_data_d  = ad_data_in;
            fft_valid_d = 1'b1;
            smp_cnt_d   = smp_cnt_q + 1'b1;
            if (smp_cnt_q == CNT_W'(N_POINTS - 1)) begin
              fft_last_d = 1'b1;
              state_d    = S_WAIT_RES;
`ifdef FFT_TIMEOUT_EN
              wd_cnt_d   = '0;
`endif
            end
          end
        end
      end

      S_WAIT_RES: begin
        if (i_stop) stop_pend_d = 1'b1;
`ifdef FFT_TIMEOUT_EN
        wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        if (fft_res_valid && fft_res_last) begin
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          // A stop arriving together with the result last still ends the run here.
          if (!cont_q || stop_pend_q || i_stop) begin
            state_d = S_IDLE;
          end else if (holdoff_q == 16'd0) begin
            state_d   = S_FILL;
            decim_d   = i_decim;
            holdoff_d = i_holdoff;
            dec_cnt_d = '0;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end
        end
`ifdef FFT_TIMEOUT_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end

      S_GAP: begin
        if (stop_pend_q) begin
          state_d = S_IDLE;
        end else begin
          if (i_stop) stop_pend_d = 1'b1;
          if (gap_cnt_q == holdoff_q - 16'd1) begin
            state_d   = S_FILL;
            decim_d   = i_decim;
            holdoff_d = i_holdoff;
            dec_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 16'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign fft_data     = fft_data_q;
  assign fft_valid    = fft_valid_q;
  assign fft_last     = fft_last_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = done_q;
  assign o_frame_cnt  = frame_cnt_q;
`ifdef FFT_TIMEOUT_EN
  assign o_err_timeout = err_q;
`else
  assign o_err_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with N_POINTS=16 and TIMEOUT_CYC=100.
`default_nettype none

module tb_fft_frame_ctrl;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_stop = 1'b0, i_continuous = 1'b0;
  logic [7:0]  i_decim = '0;
  logic [15:0] i_holdoff = '0;
  logic [15:0] ad_data_in = '0;
  logic        ad_valid = 1'b0;
  logic [15:0] fft_data;
  logic        fft_valid, fft_last;
  logic        fft_res_valid = 1'b0, fft_res_last = 1'b0;
  logic        o_busy, o_frame_done, o_err_timeout;
  logic [15:0] o_frame_cnt;

  fft_frame_ctrl #(.N_POINTS(N), .CNT_W(4), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_continuous(i_continuous), .i_decim(i_decim), .i_holdoff(i_holdoff),
    .ad_data_in(ad_data_in), .ad_valid(ad_valid),
    .fft_data(fft_data), .fft_valid(fft_valid), .fft_last(fft_last),
    .fft_res_valid(fft_res_valid), .fft_res_last(fft_res_last),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
    .o_err_timeout(o_err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] exp_q[$];       // {last, data}
  logic [15:0] exp_done_q[$];  // expected o_frame_cnt at each frame_done
  int          valid_cycs[$];
  int          done_cycs[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a sample or a frame completion.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fft_valid) begin
        valid_cycs.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_fft_valid: got data %0d expected no sample (t=%0t)", fft_data, $time);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("fft_data", fft_data, e[15:0]);
          chk("fft_last", fft_last, e[16]);
        end
      end
      if (o_frame_done) begin
        done_cycs.push_back(cyc);
        if (exp_done_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_frame_done: got cnt %0d expected no pulse (t=%0t)", o_frame_cnt, $time);
        end else begin
          chk("frame_cnt_at_done", o_frame_cnt, exp_done_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic cont, input logic [7:0] dec, input logic [15:0] hold);
    i_start = 1'b1; i_continuous = cont; i_decim = dec; i_holdoff = hold;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic push_frame(input int base, input int step);
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), 16'(base + i * step)});
  endtask

  task automatic feed(input int n, input int base, input int stop_at, input int res_at);
    for (int k = 0; k < n; k++) begin
      ad_valid = 1'b1; ad_data_in = 16'(base + k);
      i_stop = (k == stop_at);
      fft_res_valid = (k == res_at); fft_res_last = (k == res_at);
      @(posedge clk); #1;
    end
    ad_valid = 1'b0; i_stop = 1'b0; fft_res_valid = 1'b0; fft_res_last = 1'b0;
  endtask

  task automatic inject_res();
    fft_res_valid = 1'b1; fft_res_last = 1'b1;
    @(posedge clk); #1;
    fft_res_valid = 1'b0; fft_res_last = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0) && k < budget) begin
      @(posedge clk); k++;
    end
    #1;
    chk("drain_pending", exp_q.size() + exp_done_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int p;
    // Reset state
    tick(3);
    chk("rst_fft_valid", fft_valid, 0);
    chk("rst_fft_last", fft_last, 0);
    chk("rst_fft_data", fft_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_frame_cnt", o_frame_cnt, 0);
    chk("rst_err", o_err_timeout, 0);
    rst_n = 1'b1;
    tick(2);

    // Single shot, no decimation, ramp 0..15
    start(1'b0, 8'd0, 16'd0);
    chk("t1_busy", o_busy, 1);
    push_frame(0, 1);
    p = cyc;
    feed(N, 0, -1, -1);
    wait_drain(50);
    tick(20);
    chk("t1_nvalid", valid_cycs.size(), 16);
    chk("t1_first_valid_cyc", valid_cycs[0], p + 1);
    chk("t1_last_valid_cyc", valid_cycs[15], p + 16);
    chk("t1_busy_wait", o_busy, 1);
    exp_done_q.push_back(16'd1);
    inject_res();
    wait_drain(10);
    chk("t1_busy_end", o_busy, 0);
    chk("t1_frame_cnt", o_frame_cnt, 1);

    // Decimation by 3: data 0,3,...,45
    start(1'b0, 8'd2, 16'd0);
    push_frame(0, 3);
    feed(3 * N, 0, -1, -1);
    wait_drain(50);
    exp_done_q.push_back(16'd2);
    tick(3);
    inject_res();
    wait_drain(10);
    chk("t2_busy_end", o_busy, 0);
    chk("t2_frame_cnt", o_frame_cnt, 2);

    // Continuous, holdoff 5; second frame stopped at its sample 7
    valid_cycs.delete(); done_cycs.delete();
    start(1'b1, 8'd0, 16'd5);
    push_frame(100, 1);
    feed(N, 100, -1, -1);
    wait_drain(50);
    tick(20);
    exp_done_q.push_back(16'd3);
    push_frame(206, 1);   // strobes k=0..5 fall in done/GAP cycles and are dropped
    feed(22, 200, 13, 0);
    wait_drain(50);
    chk("t3_gap_latency", valid_cycs[16] - done_cycs[0], 6);
    chk("t3_nvalid", valid_cycs.size(), 32);
    chk("t4_busy_wait", o_busy, 1);
    tick(5);
    exp_done_q.push_back(16'd4);
    inject_res();
    wait_drain(10);
    chk("t4_busy_end", o_busy, 0);
    chk("t4_frame_cnt", o_frame_cnt, 4);
    feed(30, 500, -1, -1);
    tick(3);
    chk("t4_busy_after", o_busy, 0);
    chk("t4_no_more_valid", valid_cycs.size(), 32);

    // Start and stop together: stop wins
    i_start = 1'b1; i_stop = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_stop = 1'b0;
    chk("t5_busy", o_busy, 0);
    feed(10, 0, -1, -1);
    tick(2);
    chk("t5_busy_after", o_busy, 0);
    chk("t5_no_valid", valid_cycs.size(), 32);

    // Mid-frame asynchronous reset
    start(1'b0, 8'd0, 16'd0);
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 16'(i)});
    feed(4, 0, -1, -1);
    chk("t6_valid_pre", fft_valid, 1);
    chk("t6_data_pre", fft_data, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", fft_valid, 0);
    chk("t6_cnt_rst", o_frame_cnt, 0);
    chk("t6_busy_rst", o_busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // WAIT_RES with no result last
    start(1'b0, 8'd0, 16'd0);
    push_frame(0, 1);
    feed(N, 0, -1, -1);
`ifdef FFT_TIMEOUT_EN
    tick(99);
    chk("t7_err_before", o_err_timeout, 0);
    chk("t7_busy_before", o_busy, 1);
    tick(1);
    chk("t7_err_after", o_err_timeout, 1);
    chk("t7_busy_after", o_busy, 0);
    chk("t7_frame_cnt", o_frame_cnt, 0);
    start(1'b0, 8'd0, 16'd0);
    chk("t7_err_cleared", o_err_timeout, 0);
`else
    tick(150);
    chk("t7_err_tied", o_err_timeout, 0);
    chk("t7_busy_waiting", o_busy, 1);
`endif
    wait_drain(10);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    chk("end_exp_q", exp_q.size(), 0);
    chk("end_done_q", exp_done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Frame sequencer in front of fft_process. Gathers N_POINTS decimated ADC samples per frame and drives the FFT input stream with valid and last. It then holds off until the FFT result frame has fully drained before issuing the next frame. Runs single-shot or continuous, with a programmable inter-frame gap, and reports frame completion and status.

Parameters:
N_POINTS, 1024, samples per FFT frame; power of two, minimum 8
CNT_W, 10, sample counter width; equals log2(N_POINTS)
TIMEOUT_CYC, 65535, cycles allowed in WAIT_RES before timeout (used only with FFT_TIMEOUT_EN)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
i_start  input  1  start pulse; ignored unless state is IDLE
i_stop  input  1  stop request; current frame always completes
i_continuous  input  1  1 = free-run frames, 0 = single shot; sampled at i_start
i_decim  input  8  keep 1 of every (i_decim+1) ad_valid samples; latched at each frame start
i_holdoff  input  16  idle cycles between frames in continuous mode; latched at each frame start
ad_data_in  input  16  ADC sample
ad_valid  input  1  ADC sample strobe
fft_data  output  16  sample to fft_process ad_data_in
fft_valid  output  1  to fft_process i_valid
fft_last  output  1  to fft_process i_last
fft_res_valid  input  1  fft_process o_valid
fft_res_last  input  1  fft_process o_last
o_busy  output  1  high whenever state is not IDLE
o_frame_done  output  1  one-cycle pulse when a result frame completes
o_frame_cnt  output  16  completed-frame count; wraps 0xFFFF to 0
o_err_timeout  output  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-frame aborts immediately; no last is issued.
- States: IDLE, FILL, WAIT_RES, GAP.
- IDLE to FILL on i_start, only if i_stop is low in the same cycle (stop wins). On this transition: latch i_continuous, i_decim and i_holdoff; clear stop_pending, o_err_timeout, the sample counter and the decimation counter.
- FILL accepts a sample when ad_valid=1 and dec_cnt==0.
  - dec_cnt counts accepted-strobe positions 0..decim_l and wraps; it advances only on ad_valid.
  - Accepted sample: registered, 1-cycle latency. fft_data=ad_data_in, fft_valid=1.
  - fft_last=1 together with sample N_POINTS-1 (counter == N_POINTS-1). The counter then wraps to 0 and the state goes to WAIT_RES.
  - fft_valid is 0 in every cycle with no accepted sample. fft_data holds its last value.
- i_stop in FILL, WAIT_RES or GAP sets stop_pending. The frame is never truncated.
- WAIT_RES: further ad_valid is dropped.
  - On fft_res_valid & fft_res_last: pulse o_frame_done for one cycle and increment o_frame_cnt.
  - Next state: IDLE if single shot or stop_pending. Otherwise FILL if holdoff_l==0, else GAP.
- GAP: counts holdoff_l cycles, then goes to FILL and relatches i_decim and i_holdoff. stop_pending in GAP goes to IDLE on the next cycle.
- fft_res_last outside WAIT_RES is ignored.
- i_start while busy is ignored. i_continuous changes take effect only at the next i_start.
- fft_process has no backpressure. The sample at the FILL-to-WAIT_RES boundary is the Nth sample itself, so no sample is lost or duplicated.

Optional Feature:
FFT_TIMEOUT_EN
- Defined: a WAIT_RES watchdog counts cycles and is cleared on entry to WAIT_RES. On reaching TIMEOUT_CYC without a result last: set o_err_timeout (sticky until the next accepted i_start), go to IDLE, no o_frame_done, o_frame_cnt unchanged.
- Undefined: no watchdog logic. WAIT_RES waits indefinitely. o_err_timeout is tied to 0.

Test Plan:
- N_POINTS=16, i_decim=0, single shot, ad_valid continuous with ramp 0..15 → fft_valid for 16 consecutive cycles starting 1 cycle after the first accepted strobe; fft_last only on data 15; after one result last: o_frame_done=1, o_frame_cnt=1, o_busy=0.
- i_decim=2, ramp input → fft_data sequence 0,3,6,…,45; fft_last on 45.
- Continuous, i_holdoff=5, result last injected 20 cycles after fft_last → next frame's first fft_valid exactly 6 cycles after o_frame_done; o_frame_cnt increments each frame.
- i_stop asserted at sample 7 of a frame → all 16 samples still sent, then after the result last state is IDLE and no further fft_valid occurs.
- i_start and i_stop in the same cycle → stays IDLE, o_busy=0. Mid-frame rst_n low → fft_valid=0 and o_frame_cnt=0 the same cycle.
- With FFT_TIMEOUT_EN and TIMEOUT_CYC=100, no result last → o_err_timeout=1 after 100 cycles in WAIT_RES, state IDLE; next i_start clears the flag.
